alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle execute-stage ALU that consumes the 4-bit `Operation` code produced by the ALU controller and returns a registered result plus a branch-condition flag. Operands and opcode enter through a valid/ready handshake. Logic, arithmetic and compare ops complete in one cycle. Shifts run bit-serially, one position per cycle, unless the fast-shift build option is enabled.

## Interface
- `DATA_WIDTH`, 32, operand/result width; power of two, ≥ 8
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operands/opcode valid
- `in_ready`  out  1  unit can accept; high only in IDLE, low while `reset` high
- `Operation`  in  4  op code from ALU controller
- `SrcA`  in  DATA_WIDTH  operand A
- `SrcB`  in  DATA_WIDTH  operand B / shift amount / immediate
- `out_valid`  out  1  result and flag valid
- `out_ready`  in  1  consumer accepts result
- `ALUResult`  out  DATA_WIDTH  registered result
- `BranchTaken`  out  1  registered branch condition

## Operation
- Accept when `in_valid && in_ready`; latch `Operation`, `SrcA` and `SrcB`.
- Decode:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB (A−B); 0110 XOR; all mod 2^DATA_WIDTH.
  - 0100 SLL; 0101 SRL; 0111 SRA.
  - Shift amount = `SrcB[log2(DATA_WIDTH)-1:0]`; upper bits of `SrcB` ignored.
  - 1100 SLT: result = {0…, signed(A)<signed(B)}; flag 0.
  - 1000 BEQ: flag = (A==B), result 0.
  - 1011 BLT: flag = signed A<B, result 0.
  - 1101 BGE: flag = signed A≥B, result 0.
  - 1001 is shared by BNE and LUI and is resolved by driving both outputs: result = B (LUI pass-through) and flag = (A≠B).
  - 1010, 1110, 1111: result 0, flag 0.
- FSM states:
  - IDLE → DONE on accept of a non-shift op, or of a shift with amount 0.
  - IDLE → SHIFT on accept of a shift with amount n > 0.
  - SHIFT: load counter = n on entry. Each cycle shift the working register one bit (SRA replicates the MSB) and decrement the counter. Go to DONE on the cycle the counter goes 1→0.
  - DONE: `out_valid`=1, outputs held stable. Go to IDLE when `out_ready`=1.
- No new accept while in SHIFT or DONE; `in_valid` is ignored there.

## Timing
- Reset values: state IDLE, `ALUResult`=0, `BranchTaken`=0, `out_valid`=0. `in_ready`=0 during reset and 1 in the first cycle after release.
- Accept on edge T: non-shift or zero-amount shift gives `out_valid` high from T+1.
- Shift by n>0 gives `out_valid` high from T+1+n.
- Result is consumed on the edge where `out_valid && out_ready`. `in_ready` rises the cycle after. Peak throughput is one op per 2 cycles.
- `ALUResult` and `BranchTaken` are stable throughout `out_valid`. They are not cleared on return to IDLE; they are only updated on the next completion.
- Reset asserted in any state, including mid-SHIFT or DONE with a pending result: the operation is discarded and all outputs return to reset values on the next edge.
- `out_ready` held low: DONE persists indefinitely with outputs frozen.

## Configuration
- `ALU_FAST_SHIFT_EN` defined: shifts use a combinational barrel shifter. The SHIFT state is never entered, and every op completes with `out_valid` at T+1.
- Undefined (default): bit-serial shifting as described above, with latency T+1+n.

## Test plan
- ADD: A=0x7FFFFFFF, B=1, op 0010, accepted at T → `ALUResult`=0x80000000, `BranchTaken`=0, `out_valid` at T+1.
- SUB: A=5, B=7, op 0011 → 0xFFFFFFFE. XOR: A=0xF0F0F0F0, B=0xFFFF0000, op 0110 → 0x0F0FF0F0.
- SRA: A=0x80000000, B=0x24 (amount 4), op 0111 → 0xF8000000 with `out_valid` at T+5 (T+1 with `ALU_FAST_SHIFT_EN`). SLL by 0: A=0x1234 → 0x1234 at T+1.
- op 1001: A=3, B=0x12345000 → `ALUResult`=0x12345000, `BranchTaken`=1. Same op with A=B=7 → result 7, flag 0.
- Signed compares, A=0xFFFFFFFF, B=1: op 1101 → flag 0; op 1011 → flag 1; op 1100 → result 1. BEQ with A=B → flag 1, result 0.
- Back-pressure and reset:
  - Hold `out_ready`=0 for 3 cycles in DONE → outputs frozen, `in_ready`=0, new `in_valid` ignored.
  - Assert `reset` at SHIFT cycle 2 of a shift by 10 → next cycle `out_valid`=0, `ALUResult`=0, `BranchTaken`=0; `in_ready`=1 after release.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: logic/arith/compare ops plus shifts, result and branch flag registered.
// Latency: one cycle after accept; serial shifts add one cycle per position (ALU_FAST_SHIFT_EN: always one cycle).
// Backpressure: accepts only in IDLE; result held in DONE until out_ready, in_valid ignored meanwhile.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  BranchTaken
);

  localparam int SW = $clog2(DATA_WIDTH);
`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state, state_nxt;
  logic                    accept;
  logic                    is_shift;
  logic                    start_shift;
  logic [SW-1:0]           shamt;
  logic                    lt_s;
  logic signed [DATA_WIDTH-1:0] sra_all;
  logic [DATA_WIDTH-1:0]   imm_res;
  logic                    imm_flag;
  logic [3:0]              op_q;
  logic [DATA_WIDTH-1:0]   work;
  logic [DATA_WIDTH-1:0]   work_step;
  logic [SW-1:0]           cnt;

  assign shamt       = SrcB[SW-1:0];
  assign is_shift    = (Operation == 4'b0100) || (Operation == 4'b0101) || (Operation == 4'b0111);
  assign start_shift = !FAST && is_shift && (shamt != '0);
  assign in_ready    = (state == IDLE) && !reset;
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state == DONE);
  assign lt_s        = $signed(SrcA) < $signed(SrcB);
  assign sra_all     = $signed(SrcA) >>> shamt;

  // Single-cycle result and flag for the op presented at the input.
  always_comb begin
    imm_res  = '0;
    imm_flag = 1'b0;
    case (Operation)
      4'b0000: imm_res = SrcA & SrcB;
      4'b0001: imm_res = SrcA | SrcB;
      4'b0010: imm_res = SrcA + SrcB;
      4'b0011: imm_res = SrcA - SrcB;
      4'b0110: imm_res = SrcA ^ SrcB;
      // Serial build only reaches these with amount 0, where the result is A.
      4'b0100: imm_res = FAST ? (SrcA << shamt) : SrcA;
      4'b0101: imm_res = FAST ? (SrcA >> shamt) : SrcA;
      4'b0111: imm_res = FAST ? sra_all : SrcA;
      4'b1100: imm_res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      4'b1000: imm_flag = (SrcA == SrcB);
      4'b1011: imm_flag = lt_s;
      4'b1101: imm_flag = !lt_s;
      // BNE and LUI share this code: drive both outputs.
      4'b1001: begin
        imm_res  = SrcB;
        imm_flag = (SrcA != SrcB);
      end
      default: begin
        imm_res  = '0;
        imm_flag = 1'b0;
      end
    endcase
  end

  // One-position step of the serial shifter.
  always_comb begin
    work_step = work;
    case (op_q)
      4'b0100: work_step = work << 1;
      4'b0101: work_step = work >> 1;
      4'b0111: work_step = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
      default: work_step = work;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = start_shift ? SHIFT : DONE;
      SHIFT:   if (cnt == SW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, step while shifting, outputs only change on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult   <= '0;
      BranchTaken <= 1'b0;
      op_q        <= '0;
      work        <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (start_shift) begin
              op_q <= Operation;
              work <= SrcA;
              cnt  <= shamt;
            end else begin
              ALUResult   <= imm_res;
              BranchTaken <= imm_flag;
            end
          end
        end
        SHIFT: begin
          work <= work_step;
          cnt  <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            ALUResult   <= work_step;
            BranchTaken <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases then randomized ops against a behavioural model.
// Latency, outputs, hold behaviour and reset discard are all compared.
// Sampling happens on the falling edge, inputs change on the falling edge.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   Operation;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;
  logic         BranchTaken;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Operation  (Operation),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .BranchTaken(BranchTaken)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: result, flag and extra cycles spent shifting, straight from the op table.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic f, output int lat);
    int n;
    n   = int'(b % W);
    r   = '0;
    f   = 1'b0;
    lat = 0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a - b;
      4'd6:  r = a ^ b;
      4'd4:  begin r = a << n; lat = n; end
      4'd5:  begin r = a >> n; lat = n; end
      4'd7:  begin r = $signed(a) >>> n; lat = n; end
      4'd12: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd8:  f = (a == b);
      4'd11: f = ($signed(a) < $signed(b));
      4'd13: f = ($signed(a) >= $signed(b));
      4'd9:  begin r = b; f = (a != b); end
      default: ;
    endcase
`ifdef ALU_FAST_SHIFT_EN
    lat = 0;
`endif
  endfunction

  // Issue one op, check latency and outputs, optionally stall in DONE, then consume.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] er;
    logic         ef;
    int           elat;
    int           lat;
    model(op, a, b, er, ef, elat);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    SrcA     = $urandom;
    SrcB     = $urandom;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency op%0h", op), lat, elat);
    check($sformatf("result op%0h", op), ALUResult, er);
    check($sformatf("flag op%0h", op), BranchTaken, ef);
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      Operation = 4'b0010;
      @(negedge clk);
      check("hold out_valid", out_valid, 1);
      check("hold in_ready", in_ready, 0);
      check("hold result", ALUResult, er);
      check("hold flag", BranchTaken, ef);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("consumed out_valid", out_valid, 0);
    check("consumed in_ready", in_ready, 1);
    check("kept result", ALUResult, er);
    check("kept flag", BranchTaken, ef);
  endtask

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Operation = '0;
    SrcA      = '0;
    SrcB      = '0;
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset result", ALUResult, 0);
    check("reset flag", BranchTaken, 0);
    reset = 1'b0;
    #1;
    check("release in_ready", in_ready, 1);

    // Directed cases.
    do_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
    do_op(4'b0011, 32'd5, 32'd7, 0);
    do_op(4'b0110, 32'hF0F0_F0F0, 32'hFFFF_0000, 0);
    do_op(4'b0111, 32'h8000_0000, 32'h24, 0);
    do_op(4'b0100, 32'h1234, 32'h0, 0);
    do_op(4'b1001, 32'd7, 32'd7, 0);
    do_op(4'b1101, 32'hFFFF_FFFF, 32'h1, 0);
    do_op(4'b1011, 32'hFFFF_FFFF, 32'h1, 0);
    do_op(4'b1100, 32'hFFFF_FFFF, 32'h1, 0);
    do_op(4'b1000, 32'hABCD, 32'hABCD, 0);
    do_op(4'b0101, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0);
    do_op(4'b1110, 32'h1, 32'h2, 0);
    do_op(4'b0001, 32'h00F0_0F00, 32'h0F00_00F0, 3);
    do_op(4'b1001, 32'd3, 32'h1234_5000, 0);

    // Reset during the second shift cycle of a shift by 10 discards everything.
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = 4'b0100;
    SrcA      = 32'h0000_FFFF;
    SrcB      = 32'd10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midshift rst out_valid", out_valid, 0);
    check("midshift rst result", ALUResult, 0);
    check("midshift rst flag", BranchTaken, 0);
    check("midshift rst in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("midshift release in_ready", in_ready, 1);
    repeat (12) @(negedge clk);
    check("discarded out_valid", out_valid, 0);

    // Reset while a result is pending in DONE.
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = 4'b1001;
    SrcA      = 32'd1;
    SrcB      = 32'h5555_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("pending out_valid", out_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("done rst out_valid", out_valid, 0);
    check("done rst result", ALUResult, 0);
    check("done rst flag", BranchTaken, 0);
    reset = 1'b0;

    // Randomized ops.
    for (int k = 0; k < 40; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      if ($urandom_range(0, 4) == 0) rb = ra;
      do_op(rop, ra, rb, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
